// File: rtl/aes_pkg.sv
// Shared AES types, round constants, key-FSM encoding and the S-box function.
package aes_pkg;

    typedef logic [3:0][31:0] state_t;
    typedef logic [3:0]       round_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } key_state_e;

    // RCON[r] is the round constant applied when producing round key r.
    localparam logic [10:1][7:0] RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
        8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box built from the field inverse (x^254, which maps 0 to 0) and the affine map,
    // so no 256-entry table has to be maintained by hand.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        logic [7:0] b;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        b = inv;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/key_expand_round.sv
// One AES-128 key-schedule step: previous round key plus rcon gives the next round key.
module key_expand_round
    import aes_pkg::*;
(
    input  logic [127:0] i_prev,
    input  logic [7:0]   i_rcon,
    output logic [127:0] o_next
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot;
    logic [31:0] w_sub;
    logic [31:0] w_temp;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign w_w0  = i_prev[127:96];
    assign w_w1  = i_prev[95:64];
    assign w_w2  = i_prev[63:32];
    assign w_w3  = i_prev[31:0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_subword
            assign w_sub[8*gi +: 8] = sbox(w_rot[8*gi +: 8]);
        end
    endgenerate

    assign w_temp = w_sub ^ {i_rcon, 24'h000000};
    assign w_n0   = w_w0 ^ w_temp;
    assign w_n1   = w_w1 ^ w_n0;
    assign w_n2   = w_w2 ^ w_n1;
    assign w_n3   = w_w3 ^ w_n2;
    assign o_next = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/add_round_key_stage.sv
// Registered AddRoundKey stage with an internal round-key file filled by a key-expansion FSM.
module add_round_key_stage
    import aes_pkg::*;
#(
    parameter int regSize = 32,
    parameter int vecSize = 4,
    parameter int NROUNDS = 10
)(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_key_load,
    input  logic [127:0]                      i_key_in,
    output logic                              o_key_ready,
    input  logic                              i_in_valid,
    output logic                              o_in_ready,
    input  logic [vecSize-1:0][regSize-1:0]   i_in_vect,
    input  logic [3:0]                        i_in_round,
    output logic                              o_out_valid,
    input  logic                              i_out_ready,
    output logic [vecSize-1:0][regSize-1:0]   o_out_vect,
    output logic                              o_out_err
);

    generate
        if (regSize != 32 || vecSize != 4 || NROUNDS != 10) begin : g_bad_param
            $error("add_round_key_stage supports only regSize=32, vecSize=4, NROUNDS=10");
        end
    endgenerate

    localparam round_t LAST_ROUND = round_t'(NROUNDS);

    key_state_e   r_state, w_state_next;
    round_t       r_cnt, w_cnt_next;
    logic [127:0] r_prev, w_prev_next;
    logic [127:0] w_exp_next;
    logic [7:0]   w_rcon;

    logic         w_kf_we;
    round_t       w_kf_addr;
    logic [127:0] w_kf_wdata;
    logic [127:0] r_key_file [0:NROUNDS];

    logic         w_round_err;
    logic [127:0] w_rd_key;
    logic         w_accept;
    logic [vecSize-1:0][regSize-1:0] w_xor;
    logic [vecSize-1:0][regSize-1:0] w_result;

    logic         r_out_valid;
    logic         r_out_err;
    logic [vecSize-1:0][regSize-1:0] r_out_vect;

    assign w_rcon = (r_cnt >= 4'd1 && r_cnt <= 4'd10) ? RCON[r_cnt] : 8'h00;

    key_expand_round u_key_expand_round (
        .i_prev (r_prev),
        .i_rcon (w_rcon),
        .o_next (w_exp_next)
    );

    // Key FSM state, round counter and the last written round key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_prev  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_prev  <= w_prev_next;
        end
    end

    // Next-state logic; a key_load in any state restarts the schedule from the new key.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_prev_next  = r_prev;
        w_kf_we      = 1'b0;
        w_kf_addr    = r_cnt;
        w_kf_wdata   = w_exp_next;
        if (i_key_load) begin
            w_state_next = EXPAND;
            w_cnt_next   = 4'd1;
            w_prev_next  = i_key_in;
            w_kf_we      = 1'b1;
            w_kf_addr    = 4'd0;
            w_kf_wdata   = i_key_in;
        end else begin
            case (r_state)
                EXPAND: begin
                    w_kf_we     = 1'b1;
                    w_prev_next = w_exp_next;
                    w_cnt_next  = r_cnt + 4'd1;
                    if (r_cnt == LAST_ROUND) w_state_next = READY;
                end
                default: ;
            endcase
        end
    end

    // Round-key file; contents are meaningless until the FSM reaches READY, so no reset.
    always_ff @(posedge clk) begin
        if (w_kf_we) r_key_file[w_kf_addr] <= w_kf_wdata;
    end

    assign o_key_ready = (r_state == READY);
    assign o_in_ready  = o_key_ready & (~r_out_valid | i_out_ready);
    assign w_accept    = i_in_valid & o_in_ready;
    assign w_round_err = (i_in_round > LAST_ROUND);
    assign w_rd_key    = w_round_err ? 128'h0 : r_key_file[i_in_round];

    // Column i of a round key is word i, taken MSB-first from the 128-bit key.
    genvar gi;
    generate
        for (gi = 0; gi < vecSize; gi++) begin : g_col
            assign w_xor[gi] = i_in_vect[gi] ^ w_rd_key[127 - regSize*gi -: regSize];
        end
    endgenerate

    assign w_result = w_round_err ? i_in_vect : w_xor;

    // Output register: load on accept, clear valid on hand-off, hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_vect  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_err   <= w_round_err;
            r_out_vect  <= w_result;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_err   = r_out_err;
    assign o_out_vect  = r_out_vect;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Scoreboard bench for add_round_key_stage using FIPS-197 key schedule constants.
module tb_add_round_key_stage;

    logic              clk;
    logic              rst_n;
    logic              i_key_load;
    logic [127:0]      i_key_in;
    logic              o_key_ready;
    logic              i_in_valid;
    logic              o_in_ready;
    logic [3:0][31:0]  i_in_vect;
    logic [3:0]        i_in_round;
    logic              o_out_valid;
    logic              i_out_ready;
    logic [3:0][31:0]  o_out_vect;
    logic              o_out_err;

    add_round_key_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_key_load  (i_key_load),
        .i_key_in    (i_key_in),
        .o_key_ready (o_key_ready),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_vect   (i_in_vect),
        .i_in_round  (i_in_round),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_vect  (o_out_vect),
        .o_out_err   (o_out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int txn    = 0;
    int stalls = 0;
    int cur_key = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

    logic [127:0] fips_rk [0:10] = '{
        128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
        128'ha0fafe17_88542cb1_23a33939_2a6c7605,
        128'hf2c295f2_7a96b943_5935807a_7359f67f,
        128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
        128'hef44a541_a8525b7f_b671253b_db0bad00,
        128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
        128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
        128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
        128'head27321_b58dbad2_312bf560_7f8d292f,
        128'hac7766f3_19fadc21_28d12941_575c006e,
        128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6
    };
    logic [127:0] zero_rk [0:2] = '{
        128'h00000000_00000000_00000000_00000000,
        128'h62636363_62636363_62636363_62636363,
        128'h9b9898c9_f9fbfbaa_9b9898c9_f9fbfbaa
    };

    typedef struct packed {
        logic [127:0] v;
        logic         e;
    } exp_t;
    exp_t sb [$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0][31:0] v, input logic [3:0] r, input int kid);
        exp_t         x;
        logic [127:0] k;
        logic [3:0][31:0] o;
        if (r > 4'd10) begin
            x.v = v;
            x.e = 1'b1;
        end else begin
            k = (kid == 0) ? fips_rk[r] : zero_rk[(r > 4'd2) ? 2 : int'(r)];
            for (int i = 0; i < 4; i++) o[i] = v[i] ^ k[127 - 32*i -: 32];
            x.v = o;
            x.e = 1'b0;
        end
        return x;
    endfunction

    // Scoreboard: compare a hand-off first, then record an accept, both seen at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (o_out_valid && i_out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 128'd0, 128'd1);
                end else begin
                    e = sb.pop_front();
                    $display("txn %0d out=%h err=%b", txn, o_out_vect, o_out_err);
                    txn++;
                    check("out_vect", o_out_vect, e.v);
                    check("out_err", {127'd0, o_out_err}, {127'd0, e.e});
                end
            end
            if (i_in_valid && o_in_ready)
                sb.push_back(model(i_in_vect, i_in_round, cur_key));
        end
    end

    task automatic start_load(input logic [127:0] k);
        @(negedge clk);
        i_key_load = 1'b1;
        i_key_in   = k;
        @(posedge clk);
        #1;
        i_key_load = 1'b0;
    endtask

    task automatic wait_key_ready(input string tag);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k < 10) check({tag, "_low"}, {127'd0, o_key_ready}, 128'd0);
            else        check({tag, "_high"}, {127'd0, o_key_ready}, 128'd1);
        end
    endtask

    // Present one vector and return just after the edge that accepts it.
    task automatic send(input logic [3:0][31:0] v, input logic [3:0] r);
        int waitc;
        waitc      = 0;
        i_in_valid = 1'b1;
        i_in_vect  = v;
        i_in_round = r;
        @(negedge clk);
        while (!o_in_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        stalls += waitc;
        if (!o_in_ready) check("send_timeout", 128'd0, 128'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [3:0][31:0] va, vb, vr;

    initial begin
        rst_n       = 1'b0;
        i_key_load  = 1'b0;
        i_key_in    = '0;
        i_in_valid  = 1'b0;
        i_in_vect   = '0;
        i_in_round  = '0;
        i_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_key_ready", {127'd0, o_key_ready}, 128'd0);
        check("rst_out_valid", {127'd0, o_out_valid}, 128'd0);
        check("rst_out_vect", o_out_vect, 128'd0);
        check("rst_out_err", {127'd0, o_out_err}, 128'd0);
        check("rst_in_ready", {127'd0, o_in_ready}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Key schedule latency with the FIPS-197 key.
        cur_key = 0;
        start_load(FIPS_KEY);
        wait_key_ready("kr_fips");

        // Last round key applied to an all-zero state.
        send('0, 4'd10);
        i_in_valid = 1'b0;
        check("r10_valid", {127'd0, o_out_valid}, 128'd1);
        check("r10_col0", {96'd0, o_out_vect[0]}, {96'd0, 32'hd014f9a8});
        check("r10_col3", {96'd0, o_out_vect[3]}, {96'd0, 32'hb6630ca6});
        idle(2);

        // Back-to-back stream over rounds 0..7.
        stalls = 0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 4; c++) vr[c] = $urandom;
            send(vr, 4'(r));
        end
        check("stream_no_stall", 128'(stalls), 128'd0);
        idle(3);
        check("stream_drained", 128'(sb.size()), 128'd0);

        // Backpressure: held output stays stable, then resumes with no bubble.
        i_out_ready = 1'b0;
        for (int c = 0; c < 4; c++) va[c] = $urandom;
        for (int c = 0; c < 4; c++) vb[c] = $urandom;
        send(va, 4'd3);
        i_in_vect  = vb;
        i_in_round = 4'd4;
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", {127'd0, o_out_valid}, 128'd1);
            check("hold_vect", o_out_vect, model(va, 4'd3, 0).v);
            check("hold_in_ready", {127'd0, o_in_ready}, 128'd0);
            @(posedge clk);
            #1;
        end
        i_out_ready = 1'b1;
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        check("nobubble_valid", {127'd0, o_out_valid}, 128'd1);
        check("nobubble_vect", o_out_vect, model(vb, 4'd4, 0).v);
        idle(2);

        // Out-of-range round passes the vector through and flags an error.
        va = {4{32'h11223344}};
        send(va, 4'd12);
        i_in_valid = 1'b0;
        check("bad_round_err", {127'd0, o_out_err}, 128'd1);
        check("bad_round_vect", o_out_vect, va);
        idle(2);

        // Held output survives a reload; a second load mid-expansion aborts the first.
        i_out_ready = 1'b0;
        for (int c = 0; c < 4; c++) vr[c] = $urandom;
        send(vr, 4'd5);
        i_in_valid = 1'b0;
        start_load(FIPS_KEY);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("reload_in_ready", {127'd0, o_in_ready}, 128'd0);
        end
        cur_key = 1;
        start_load(128'd0);
        wait_key_ready("kr_zero");
        check("reload_held_valid", {127'd0, o_out_valid}, 128'd1);
        check("reload_held_vect", o_out_vect, model(vr, 4'd5, 0).v);
        i_out_ready = 1'b1;
        @(posedge clk);
        #1;
        send('0, 4'd0);
        send('0, 4'd1);
        send('0, 4'd2);
        i_in_valid = 1'b0;
        check("zero_rk2_col1", {96'd0, o_out_vect[1]}, {96'd0, 32'hf9fbfbaa});
        idle(3);
        check("zero_drained", 128'(sb.size()), 128'd0);

        // Asynchronous reset with a vector in flight.
        i_out_ready = 1'b0;
        for (int c = 0; c < 4; c++) vr[c] = $urandom;
        send(vr, 4'd3);
        i_in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {127'd0, o_out_valid}, 128'd0);
        check("arst_key_ready", {127'd0, o_key_ready}, 128'd0);
        check("arst_out_vect", o_out_vect, 128'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("post_rst_no_key", {127'd0, o_key_ready}, 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
